// File: rtl/clock_alarm_core.sv
// BCD time-of-day counter with set-time load and a ringing alarm that supports snooze.
// Output sec_tick is combinational from the divider; alarm is decoded from the FSM state.
module clock_alarm_core #(
    parameter int TICK_DIV   = 25000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic       MHz_25,
    input  logic       reset_n,
    input  logic       set_time,
    input  logic [7:0] hours_set,
    input  logic [7:0] minutes_set,
    input  logic [7:0] hours_alarm,
    input  logic [7:0] minutes_alarm,
    input  logic       alarm_en,
    input  logic       snooze,
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       sec_tick,
    output logic       alarm
);
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RINGING = 2'd1;
    localparam logic [1:0] ST_SNOOZED = 2'd2;

    logic [DIV_W-1:0] div_reg;
    logic [7:0]       hr_reg, min_reg, sec_reg;
    logic [7:0]       hr_next, min_next, sec_next;
    logic             sec_wrap, min_wrap;
    logic             match_reg;
    logic             snooze_d_reg;
    logic             snooze_rise;
    logic [1:0]       state_reg;
    logic [CNT_W-1:0] ring_cnt_reg, snz_cnt_reg;

    // Wrapping is handled by the caller; this only steps a two-digit BCD value.
    function automatic logic [7:0] bcd_step(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    assign sec_wrap = (sec_reg == 8'h59);
    assign min_wrap = (min_reg == 8'h59);

    always_comb begin
        sec_next = sec_wrap ? 8'h00 : bcd_step(sec_reg);
        min_next = min_reg;
        hr_next  = hr_reg;
        if (sec_wrap) begin
            min_next = min_wrap ? 8'h00 : bcd_step(min_reg);
            if (min_wrap)
                hr_next = (hr_reg == 8'h23) ? 8'h00 : bcd_step(hr_reg);
        end
    end

    assign sec_tick    = (div_reg == DIV_LAST) && !set_time;
    assign snooze_rise = snooze && !snooze_d_reg;

    always_ff @(posedge MHz_25 or negedge reset_n) begin
        if (!reset_n) begin
            div_reg   <= '0;
            hr_reg    <= 8'h00;
            min_reg   <= 8'h00;
            sec_reg   <= 8'h00;
            match_reg <= 1'b0;
        end else if (set_time) begin
            // Each field is validated on its own so a bad hours value cannot block a good minutes load.
            div_reg   <= '0;
            sec_reg   <= 8'h00;
            match_reg <= 1'b0;
            if (bcd_ok(hours_set, 8'h23))
                hr_reg <= hours_set;
            if (bcd_ok(minutes_set, 8'h59))
                min_reg <= minutes_set;
        end else if (sec_tick) begin
            div_reg   <= '0;
            hr_reg    <= hr_next;
            min_reg   <= min_next;
            sec_reg   <= sec_next;
            match_reg <= ({hr_next, min_next, sec_next} == {hours_alarm, minutes_alarm, 8'h00});
        end else begin
            div_reg   <= div_reg + 1'b1;
            match_reg <= 1'b0;
        end
    end

    always_ff @(posedge MHz_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            ring_cnt_reg <= '0;
            snz_cnt_reg  <= '0;
            snooze_d_reg <= 1'b0;
        end else begin
            snooze_d_reg <= snooze;
            if (!alarm_en || set_time) begin
                state_reg    <= ST_IDLE;
                ring_cnt_reg <= '0;
                snz_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (match_reg) begin
                            state_reg    <= ST_RINGING;
                            ring_cnt_reg <= RING_LOAD;
                        end
                    end
                    ST_RINGING: begin
                        if (snooze_rise) begin
                            state_reg   <= ST_SNOOZED;
                            snz_cnt_reg <= SNOOZE_LOAD;
                        end else if (sec_tick) begin
                            if (ring_cnt_reg <= CNT_ONE) begin
                                state_reg    <= ST_IDLE;
                                ring_cnt_reg <= '0;
                            end else begin
                                ring_cnt_reg <= ring_cnt_reg - 1'b1;
                            end
                        end
                    end
                    ST_SNOOZED: begin
                        if (sec_tick) begin
                            if (snz_cnt_reg <= CNT_ONE) begin
                                state_reg    <= ST_RINGING;
                                ring_cnt_reg <= RING_LOAD;
                                snz_cnt_reg  <= '0;
                            end else begin
                                snz_cnt_reg <= snz_cnt_reg - 1'b1;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign hours   = hr_reg;
    assign minutes = min_reg;
    assign seconds = sec_reg;
    assign alarm   = (state_reg == ST_RINGING);

endmodule
